// File: rtl/switch_allocator_if.sv
// Request/grant bundle between router input stages and the switch allocator.
// o_grant_cnt exists only when SA_PERF_CNT_EN is defined.
interface switch_allocator_if #(
  parameter int NUM_PORTS = 5,
  parameter int CNT_W     = 16
);
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] i_req;
  logic [NUM_PORTS-1:0]                i_head;
  logic [NUM_PORTS-1:0]                i_tail;
  logic [NUM_PORTS-1:0]                i_on_off;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] o_grant;
  logic [NUM_PORTS-1:0]                o_valid;
  logic [NUM_PORTS-1:0]                o_busy;

  // Counter width only shapes hardware when the counters are built in.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end

`ifdef SA_PERF_CNT_EN
  logic [NUM_PORTS-1:0][CNT_W-1:0]     o_grant_cnt;

  modport master (
    output i_req, i_head, i_tail, i_on_off,
    input  o_grant, o_valid, o_busy, o_grant_cnt
  );
  modport slave (
    input  i_req, i_head, i_tail, i_on_off,
    output o_grant, o_valid, o_busy, o_grant_cnt
  );
`else
  modport master (
    output i_req, i_head, i_tail, i_on_off,
    input  o_grant, o_valid, o_busy
  );
  modport slave (
    input  i_req, i_head, i_tail, i_on_off,
    output o_grant, o_valid, o_busy
  );
`endif
endinterface

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration with packet locking.
// Define SA_PERF_CNT_EN to add saturating per-output grant counters.
module switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  switch_allocator_if.slave sa
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
  typedef logic [NUM_PORTS-1:0] vec_t;

  state_e           state_q [NUM_PORTS];
  state_e           state_d [NUM_PORTS];
  logic [PTR_W-1:0] owner_q [NUM_PORTS];
  logic [PTR_W-1:0] owner_d [NUM_PORTS];
  logic [PTR_W-1:0] rr_q    [NUM_PORTS];
  logic [PTR_W-1:0] rr_d    [NUM_PORTS];
  vec_t             req_eff [NUM_PORTS];
  vec_t             grant   [NUM_PORTS];

  if (CNT_W < 1) begin : g_cnt_w_unused
  end

  function automatic vec_t lowest_req(vec_t v);
    return v & (~v + vec_t'(1));
  endfunction

  // An input only competes for its lowest-numbered requested output, so it can
  // never be granted by two outputs in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_eff[i] = lowest_req(sa.i_req[i]);
    end
  end

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      grant[o]   = '0;
      found      = 1'b0;
      win        = '0;
      if (sa.i_on_off[o]) begin
        if (state_q[o] == IDLE) begin
          for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = PTR_W'((int'(rr_q[o]) + k) % NUM_PORTS);
            if (!found && req_eff[idx][o] && sa.i_head[idx]) begin
              found = 1'b1;
              win   = idx;
            end
          end
          if (found) begin
            grant[o][win] = 1'b1;
            if (sa.i_tail[win]) begin
              rr_d[o] = win;
            end else begin
              state_d[o] = LOCKED;
              owner_d[o] = win;
            end
          end
        end else if (req_eff[owner_q[o]][o]) begin
          grant[o][owner_q[o]] = 1'b1;
          if (sa.i_tail[owner_q[o]]) begin
            state_d[o] = IDLE;
            rr_d[o]    = owner_q[o];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (reset_n) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= PTR_W'(NUM_PORTS - 1);
      end else begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

  // Reset is active-high despite its name; outputs are held quiet while it is asserted.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      sa.o_grant[o] = reset_n ? '0 : grant[o];
      sa.o_valid[o] = !reset_n && (|grant[o]);
      sa.o_busy[o]  = !reset_n && (state_q[o] == LOCKED);
    end
  end

`ifdef SA_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PORTS];
  logic [CNT_W-1:0] cnt_d [NUM_PORTS];

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cnt_d[o]          = (|grant[o]) ? sat_inc(cnt_q[o]) : cnt_q[o];
      sa.o_grant_cnt[o] = cnt_q[o];
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (reset_n) cnt_q[o] <= '0;
      else         cnt_q[o] <= cnt_d[o];
    end
  end
`endif

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of router input and output ports (LOCAL, NORTH, SOUTH, EAST, WEST order from router_pkg).
REQ-002 Parameter CNT_W, default 16, width of each grant counter (used only with SA_PERF_CNT_EN).
REQ-003 clk  in  1  single clock, all state updates on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-high reset; asserted = 1 despite the name.
REQ-005 i_req[NUM_PORTS]  in  NUM_PORTS each  i_req[i][o]=1: input i has a flit routed to output o.
REQ-006 i_head[NUM_PORTS]  in  1 each  flit at input i is a head flit.
REQ-007 i_tail[NUM_PORTS]  in  1 each  flit at input i is a tail flit; head and tail both 1 = single-flit packet.
REQ-008 i_on_off[NUM_PORTS]  in  1 each  downstream on/off for output o; 1 = output may forward this cycle.
REQ-009 o_grant[NUM_PORTS]  out  NUM_PORTS each  o_grant[o][i]=1: output o forwards input i's flit this cycle.
REQ-010 o_valid[NUM_PORTS]  out  1 each  output o forwards a flit this cycle (OR of o_grant[o]).
REQ-011 o_busy[NUM_PORTS]  out  1 each  output o locked to a packet in progress.
REQ-012 o_grant_cnt[NUM_PORTS]  out  CNT_W each  flits forwarded per output (present only with SA_PERF_CNT_EN).

Function
REQ-013 Each output shall have an independent two-state FSM: IDLE, LOCKED; per-output registers owner and rr_ptr (clog2(NUM_PORTS) bits).
REQ-014 If an input asserts more than one i_req bit, only its lowest-index output shall be considered; others ignored that cycle.
REQ-015 Grants shall be combinational from current state and inputs (zero-cycle latency); state updates on the next rising edge.
REQ-016 o_grant[o] shall be one-hot or zero; no input shall be granted by two outputs in the same cycle.
REQ-017 No grant and no state change for output o when i_on_off[o]=0.
REQ-018 IDLE: candidates = inputs with i_req[i][o]=1 and i_head[i]=1; winner = first candidate strictly after rr_ptr[o], wrapping NUM_PORTS-1 -> 0.
REQ-019 IDLE with winner w and i_tail[w]=0: grant w, owner<=w, go LOCKED, o_busy=1 next cycle.
REQ-020 IDLE with winner w and i_tail[w]=1: grant w, stay IDLE, rr_ptr<=w.
REQ-021 IDLE: requests with i_head=0 shall be ignored (no grant).
REQ-022 LOCKED: grant only owner, only when i_req[owner][o]=1; all other requests ignored regardless of head.
REQ-023 LOCKED with owner granted and i_tail[owner]=1: go IDLE, rr_ptr<=owner, o_busy=0 next cycle.
REQ-024 LOCKED with owner not requesting (bubble): no grant, remain LOCKED indefinitely.
REQ-025 Owner losing on/off mid-packet: hold LOCKED, resume granting owner when i_on_off returns to 1.
REQ-026 o_busy[o] shall equal (state==LOCKED), registered.

Reset
REQ-027 While reset_n=1 at a rising edge: all FSMs IDLE, owner=0, rr_ptr=NUM_PORTS-1 (input 0 first priority), counters 0.
REQ-028 While reset_n=1, o_grant, o_valid, o_busy shall be forced to 0.
REQ-029 Reset mid-packet shall release every lock; the first post-reset flit needs i_head=1 to be granted.

Configuration
REQ-030 Macro SA_PERF_CNT_EN defined: o_grant_cnt[o] increments by 1 on each cycle o_valid[o]=1, saturating at all-ones, cleared by reset.
REQ-031 Macro SA_PERF_CNT_EN undefined: o_grant_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-032 Inputs 0,1,2 send single-flit packets (head=tail=1) to output 3 every cycle, on=1 -> grants 0,1,2,0,1,2 on consecutive cycles.
REQ-033 Input 1 sends 4-flit packet to output 2 while input 4 holds a head for output 2 -> grants 1 x4, then 4 the cycle after tail; o_busy[2]=1 for the cycles after head through the tail cycle.
REQ-034 i_on_off[2]=0 for 3 cycles mid-packet -> o_grant[2]=0 those cycles, o_busy[2] stays 1, remaining flits granted to same owner after on=1.
REQ-035 reset_n=1 for one cycle while output 0 LOCKED -> next cycle o_busy[0]=0; a body flit (head=0) from old owner is not granted; a new head from input 0 is granted.
REQ-036 Input 3 requests outputs 1 and 4 simultaneously (i_req[3]=5'b10010) -> only o_grant[1][3]=1, o_valid[4]=0.
REQ-037 SA_PERF_CNT_EN with CNT_W=4, 20 forwarded flits on output 0 -> o_grant_cnt[0]=15 and holds.
